// File: rtl/pps_seconds_counter.sv
// -----------------------------------------------------------------------------
// pps_seconds_counter
//
// Free-running seconds / sub-second counter that disciplines itself to an
// external PPS pulse. Without PPS it runs at CLKS_PER_SEC cycles per second
// (state FREE). The first PPS edge aligns the second boundary to it and moves
// to LOCKED. While LOCKED, PPS edges close to the internal boundary (within
// PPS_WINDOW cycles on either side) keep it aligned. Edges far from the
// boundary are counted as errors and drop the lock. MISS_LIMIT consecutive
// seconds without any PPS edge also drop the lock. Software can preset the
// seconds count; the preset lands on the next second boundary.
//
// Ports
//   user_clk     in   1  sole clock, rising edge
//   user_rst     in   1  synchronous active-high reset
//   pps_in       in   1  asynchronous PPS pulse (>= 3 user_clk cycles wide)
//   load_stb     in   1  one-cycle request to preset the seconds count
//   load_val     in  32  preset value, sampled with load_stb
//   seconds      out 32  seconds count
//   subsec       out 32  cycle count within the current second
//   pps_out      out  1  one-cycle pulse on every second boundary
//   locked       out  1  high while in state LOCKED
//   pps_err_cnt  out 16  out-of-window PPS edges, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module pps_seconds_counter #(
   parameter int unsigned CLKS_PER_SEC = 128000000,
   parameter int unsigned PPS_WINDOW   = 16,
   parameter int unsigned MISS_LIMIT   = 3
) (
   input  logic        user_clk,
   input  logic        user_rst,
   input  logic        pps_in,
   input  logic        load_stb,
   input  logic [31:0] load_val,
   output logic [31:0] seconds,
   output logic [31:0] subsec,
   output logic        pps_out,
   output logic        locked,
   output logic [15:0] pps_err_cnt
);

   localparam logic [31:0] C_LAST  = 32'(CLKS_PER_SEC - 1);
   localparam logic [31:0] C_EARLY = 32'(CLKS_PER_SEC - PPS_WINDOW);
   localparam logic [31:0] C_LATE  = 32'(PPS_WINDOW);
   // One spare code so the counter can always represent MISS_LIMIT itself.
   localparam int unsigned MISS_W  = $clog2(MISS_LIMIT + 2);
   localparam logic [MISS_W-1:0] C_MISS_LIM = MISS_W'(MISS_LIMIT);

   typedef enum logic {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
      return (v >= C_MISS_LIM) ? v : v + MISS_W'(1);
   endfunction

   logic              r_pps_sync_p0;
   logic              r_pps_sync_p1;
   logic              r_pps_prev_p2;
   state_t            r_state;
   logic [MISS_W-1:0] r_miss;
   logic              r_seen;
   logic [31:0]       r_subsec;
   logic [31:0]       r_seconds;
   logic              r_pps_out;
   logic              r_locked;
   logic [15:0]       r_err_cnt;
   logic              r_load_pend;
   logic [31:0]       r_load_val;

   logic              w_pps_edge;
   logic              w_at_last;
   logic [MISS_W-1:0] w_miss_inc;
   state_t            w_state_nxt;
   logic              w_boundary;
   logic              w_realign;
   logic [MISS_W-1:0] w_miss_nxt;
   logic              w_seen_nxt;
   logic              w_err_inc;
   logic [31:0]       w_seconds_nxt;
   logic              w_load_pend_nxt;
   logic [31:0]       w_load_val_nxt;

   // ---- stage p1/p2: synchronised PPS and its one-cycle-delayed copy ----
   assign w_pps_edge = r_pps_sync_p1 & ~r_pps_prev_p2;
   assign w_at_last  = (r_subsec == C_LAST);
   assign w_miss_inc = sat_inc_miss(r_miss);

   // Timing FSM: decides boundaries, re-alignment, misses and lock state.
   always_comb begin
      w_state_nxt = r_state;
      w_boundary  = 1'b0;
      w_realign   = 1'b0;
      w_miss_nxt  = r_miss;
      w_err_inc   = 1'b0;

      unique case (r_state)
         ST_FREE: begin
            if (w_pps_edge) begin
               w_boundary  = 1'b1;
               w_state_nxt = ST_LOCKED;
               w_miss_nxt  = '0;
            end else if (w_at_last) begin
               w_boundary = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (w_pps_edge) begin
               // An edge on the last cycle falls in the early window, so it
               // yields exactly one boundary.
               if (r_subsec >= C_EARLY) begin
                  w_boundary = 1'b1;
                  w_miss_nxt = '0;
               end else if (r_subsec < C_LATE) begin
                  // Late PPS: the boundary already happened; just re-zero.
                  w_realign  = 1'b1;
                  w_miss_nxt = '0;
               end else begin
                  w_err_inc   = 1'b1;
                  w_state_nxt = ST_FREE;
               end
            end else if (w_at_last) begin
               w_boundary = 1'b1;
               if (!r_seen) begin
                  w_miss_nxt = w_miss_inc;
                  if (w_miss_inc >= C_MISS_LIM) begin
                     w_state_nxt = ST_FREE;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = ST_FREE;
         end
      endcase

      // "Edge seen since the previous boundary"; a boundary restarts it.
      w_seen_nxt = w_boundary ? 1'b0 : (r_seen | w_pps_edge);
   end

   // Seconds update with deferred preset.
   always_comb begin
      w_seconds_nxt   = r_seconds;
      w_load_pend_nxt = r_load_pend;
      w_load_val_nxt  = r_load_val;
      if (w_boundary) begin
         w_load_pend_nxt = 1'b0;
         if (load_stb) begin
            w_seconds_nxt = load_val;
         end else if (r_load_pend) begin
            w_seconds_nxt = r_load_val;
         end else begin
            w_seconds_nxt = r_seconds + 32'd1;
         end
      end else if (load_stb) begin
         w_load_pend_nxt = 1'b1;
         w_load_val_nxt  = load_val;
      end
   end

   // ---- stage p0: PPS sampling and all state registers ----
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         r_pps_sync_p0 <= 1'b0;
         r_pps_sync_p1 <= 1'b0;
         r_pps_prev_p2 <= 1'b0;
         r_state       <= ST_FREE;
         r_miss        <= '0;
         r_seen        <= 1'b0;
         r_subsec      <= '0;
         r_seconds     <= '0;
         r_pps_out     <= 1'b0;
         r_locked      <= 1'b0;
         r_err_cnt     <= '0;
         r_load_pend   <= 1'b0;
         r_load_val    <= '0;
      end else begin
         r_pps_sync_p0 <= pps_in;
         r_pps_sync_p1 <= r_pps_sync_p0;
         r_pps_prev_p2 <= r_pps_sync_p1;
         r_state       <= w_state_nxt;
         r_miss        <= w_miss_nxt;
         r_seen        <= w_seen_nxt;
         r_subsec      <= (w_boundary || w_realign) ? 32'd0 : r_subsec + 32'd1;
         r_seconds     <= w_seconds_nxt;
         r_pps_out     <= w_boundary;
         // Registered from the next state so it always matches r_state.
         r_locked      <= (w_state_nxt == ST_LOCKED);
         r_err_cnt     <= w_err_inc ? sat_inc16(r_err_cnt) : r_err_cnt;
         r_load_pend   <= w_load_pend_nxt;
         r_load_val    <= w_load_val_nxt;
      end
   end

   assign seconds     = r_seconds;
   assign subsec      = r_subsec;
   assign pps_out     = r_pps_out;
   assign locked      = r_locked;
   assign pps_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_pps_seconds_counter.sv
module tb_pps_seconds_counter;

   localparam int CPS  = 100;
   localparam int WIN  = 4;
   localparam int MLIM = 3;

   logic        user_clk = 1'b0;
   logic        user_rst;
   logic        pps_in;
   logic        load_stb;
   logic [31:0] load_val;
   logic [31:0] seconds;
   logic [31:0] subsec;
   logic        pps_out;
   logic        locked;
   logic [15:0] pps_err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pps_seconds_counter #(
      .CLKS_PER_SEC(CPS),
      .PPS_WINDOW  (WIN),
      .MISS_LIMIT  (MLIM)
   ) dut (
      .user_clk   (user_clk),
      .user_rst   (user_rst),
      .pps_in     (pps_in),
      .load_stb   (load_stb),
      .load_val   (load_val),
      .seconds    (seconds),
      .subsec     (subsec),
      .pps_out    (pps_out),
      .locked     (locked),
      .pps_err_cnt(pps_err_cnt)
   );

   always #5 user_clk = ~user_clk;

   // Reference model. Time is kept as absolute cycle stamps: subsec is the
   // distance from the last zeroing, "PPS seen this second" is a comparison
   // of the last-edge and last-boundary stamps.
   int          m_cyc;
   int          m_zero;
   int          m_last_edge;
   int          m_last_bnd;
   int          m_miss;
   int          m_err;
   logic [31:0] m_sec;
   logic [31:0] m_pval;
   bit          m_locked;
   bit          m_pend;
   bit          m_pps;
   bit          m_hist[3];

   function automatic int m_sub();
      return m_cyc - m_zero;
   endfunction

   task automatic model_update();
      bit ev;
      bit seen;
      bit bnd;
      bit zero;
      int s;
      if (user_rst) begin
         m_cyc = 0; m_zero = 0; m_last_edge = -1; m_last_bnd = 0;
         m_miss = 0; m_err = 0; m_sec = '0; m_pval = '0;
         m_locked = 0; m_pend = 0; m_pps = 0;
         m_hist = '{0, 0, 0};
      end else begin
         // The edge acts two samples after pps_in is first seen high.
         ev   = m_hist[1] && !m_hist[2];
         seen = (m_last_edge > m_last_bnd);
         s    = m_sub();
         m_cyc++;
         bnd  = 0;
         zero = 0;
         if (!m_locked) begin
            if (ev) begin bnd = 1; m_locked = 1; m_miss = 0; end
            else if (s == CPS - 1) bnd = 1;
         end else if (ev) begin
            if (s >= CPS - WIN) begin bnd = 1; m_miss = 0; end
            else if (s < WIN) begin zero = 1; m_miss = 0; end
            else begin
               if (m_err < 65535) m_err++;
               m_locked = 0;
            end
         end else if (s == CPS - 1) begin
            bnd = 1;
            if (!seen) begin
               m_miss++;
               if (m_miss >= MLIM) m_locked = 0;
            end
         end
         if (ev) m_last_edge = m_cyc;
         if (bnd) m_last_bnd = m_cyc;
         if (bnd || zero) m_zero = m_cyc;
         if (bnd) begin
            if (load_stb) m_sec = load_val;
            else if (m_pend) m_sec = m_pval;
            else m_sec = m_sec + 32'd1;
            m_pend = 0;
         end else if (load_stb) begin
            m_pend = 1;
            m_pval = load_val;
         end
         m_pps = bnd;
         m_hist[2] = m_hist[1];
         m_hist[1] = m_hist[0];
         m_hist[0] = pps_in;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: model advances on the rising edge, DUT compared on the falling edge.
   task automatic step();
      @(posedge user_clk);
      model_update();
      @(negedge user_clk);
      check("seconds", seconds, m_sec);
      check("subsec", subsec, 32'(m_sub()));
      check("pps_out", 32'(pps_out), 32'(m_pps));
      check("locked", 32'(locked), 32'(m_locked));
      check("pps_err_cnt", 32'(pps_err_cnt), 32'(m_err));
   endtask

   task automatic wait_sub(input int v);
      int guard;
      guard = 0;
      while (m_sub() != v && guard < 400) begin
         step();
         guard++;
      end
      if (m_sub() != v) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_sub timeout: subsec=%0d required=%0d", m_sub(), v);
      end
   endtask

   task automatic wait_pps(output int n);
      n = -1;
      for (int i = 1; i <= 150; i++) begin
         step();
         if (pps_out) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic lock_now();
      wait_sub(30);
      pps_in = 1'b1;
      step(); step(); step();
      pps_in = 1'b0;
      check("lock_now_locked", 32'(locked), 32'd1);
   endtask

   typedef struct {
      int det;        // subsec while the synchronised edge is presented
      int dsec;       // expected seconds change
      int sub_after;  // expected subsec after the edge acts
      bit pps;        // expected pps_out
      bit lck;        // expected locked
      int derr;       // expected pps_err_cnt change
   } vec_t;

   vec_t        tbl[8];
   int          pulses[$];
   int          n;
   logic [31:0] snap_sec;
   int          snap_err;
   int          gap;
   int          hold;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{97, 1,  0, 1'b1, 1'b1, 0};
      tbl[1] = '{99, 1,  0, 1'b1, 1'b1, 0};
      tbl[2] = '{96, 1,  0, 1'b1, 1'b1, 0};
      tbl[3] = '{ 2, 0,  0, 1'b0, 1'b1, 0};
      tbl[4] = '{ 3, 0,  0, 1'b0, 1'b1, 0};
      tbl[5] = '{50, 0, 51, 1'b0, 1'b0, 1};
      tbl[6] = '{95, 0, 96, 1'b0, 1'b0, 1};
      tbl[7] = '{ 4, 0,  5, 1'b0, 1'b0, 1};

      user_rst = 1'b1;
      pps_in   = 1'b0;
      load_stb = 1'b0;
      load_val = '0;
      step(); step(); step();
      check("rst_seconds", seconds, 32'd0);
      check("rst_subsec", subsec, 32'd0);
      check("rst_pps_out", 32'(pps_out), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_err", 32'(pps_err_cnt), 32'd0);
      user_rst = 1'b0;

      // Free run without PPS.
      pulses.delete();
      for (int i = 1; i <= 250; i++) begin
         step();
         if (pps_out) pulses.push_back(i);
      end
      check("free_npulses", 32'(pulses.size()), 32'd2);
      check("free_pulse1", 32'(pulses[0]), 32'd100);
      check("free_pulse2", 32'(pulses[1]), 32'd200);
      check("free_seconds", seconds, 32'd2);
      check("free_subsec", subsec, 32'd50);
      check("free_locked", 32'(locked), 32'd0);

      // First PPS in FREE at subsec 40.
      wait_sub(40);
      pps_in = 1'b1;
      step(); step(); step();
      pps_in = 1'b0;
      check("acq_seconds", seconds, 32'd4);
      check("acq_subsec", subsec, 32'd0);
      check("acq_pps_out", 32'(pps_out), 32'd1);
      check("acq_locked", 32'(locked), 32'd1);

      // PPS arrival position while LOCKED.
      for (int i = 0; i < 8; i++) begin
         if (!m_locked) lock_now();
         wait_sub(10);
         wait_sub(tbl[i].det - 2);
         snap_sec = m_sec;
         snap_err = m_err;
         pps_in = 1'b1;
         step(); step(); step();
         check($sformatf("tbl%0d_det%0d_seconds", i, tbl[i].det), seconds, snap_sec + 32'(tbl[i].dsec));
         check($sformatf("tbl%0d_det%0d_subsec", i, tbl[i].det), subsec, 32'(tbl[i].sub_after));
         check($sformatf("tbl%0d_det%0d_pps_out", i, tbl[i].det), 32'(pps_out), 32'(tbl[i].pps));
         check($sformatf("tbl%0d_det%0d_locked", i, tbl[i].det), 32'(locked), 32'(tbl[i].lck));
         check($sformatf("tbl%0d_det%0d_err", i, tbl[i].det), 32'(pps_err_cnt), 32'(snap_err + tbl[i].derr));
         pps_in = 1'b0;
         step();
      end

      // PPS removed while LOCKED: lock drops on the third missed boundary.
      lock_now();
      pulses.delete();
      for (int i = 1; i <= 300; i++) begin
         step();
         if (pps_out) pulses.push_back(i);
         if (i == 200) check("miss_locked_b2", 32'(locked), 32'd1);
         if (i == 299) check("miss_locked_pre_b3", 32'(locked), 32'd1);
      end
      check("miss_npulses", 32'(pulses.size()), 32'd3);
      check("miss_pulse1", 32'(pulses[0]), 32'd100);
      check("miss_pulse2", 32'(pulses[1]), 32'd200);
      check("miss_pulse3", 32'(pulses[2]), 32'd300);
      check("miss_locked_b3", 32'(locked), 32'd0);

      // Deferred preset.
      wait_sub(10);
      snap_sec = m_sec;
      load_stb = 1'b1;
      load_val = 32'h12345678;
      step();
      load_stb = 1'b0;
      check("load_sec_unchanged", seconds, snap_sec);
      check("load_subsec", subsec, 32'd11);
      wait_pps(n);
      check("load_boundary_dist", 32'(n), 32'd89);
      check("load_seconds", seconds, 32'h12345678);
      wait_pps(n);
      check("load_next_dist", 32'(n), 32'd100);
      check("load_next_seconds", seconds, 32'h12345679);

      // Second load before the boundary overwrites the first.
      wait_sub(10);
      load_stb = 1'b1; load_val = 32'h0BADBEEF; step(); load_stb = 1'b0;
      wait_sub(20);
      load_stb = 1'b1; load_val = 32'h55AA55AA; step(); load_stb = 1'b0;
      wait_pps(n);
      check("overwrite_seconds", seconds, 32'h55AA55AA);

      // Load coincident with the boundary.
      wait_sub(99);
      load_stb = 1'b1;
      load_val = 32'hCAFEF00D;
      step();
      load_stb = 1'b0;
      check("coinc_seconds", seconds, 32'hCAFEF00D);
      check("coinc_pps_out", 32'(pps_out), 32'd1);
      check("coinc_subsec", subsec, 32'd0);
      wait_pps(n);
      check("coinc_next_seconds", seconds, 32'hCAFEF00E);

      // Reset mid-second with a load pending.
      lock_now();
      wait_sub(50);
      load_stb = 1'b1; load_val = 32'hDEAD0000; step(); load_stb = 1'b0;
      wait_sub(60);
      user_rst = 1'b1;
      step();
      check("mrst_seconds", seconds, 32'd0);
      check("mrst_subsec", subsec, 32'd0);
      check("mrst_pps_out", 32'(pps_out), 32'd0);
      check("mrst_locked", 32'(locked), 32'd0);
      check("mrst_err", 32'(pps_err_cnt), 32'd0);
      step();
      user_rst = 1'b0;
      n = -1;
      for (int i = 1; i <= 150; i++) begin
         step();
         if (i == 1) check("mrst_resume_subsec", subsec, 32'd1);
         if (pps_out) begin
            n = i;
            break;
         end
      end
      check("mrst_first_pps", 32'(n), 32'd100);
      check("mrst_seconds_after", seconds, 32'd1);

      // Randomised PPS jitter, dropouts, loads and resets against the model.
      gap  = 60;
      hold = 0;
      for (int c = 0; c < 20000; c++) begin
         if (hold > 0) begin
            pps_in = 1'b1;
            hold--;
         end else if (gap > 0) begin
            pps_in = 1'b0;
            gap--;
         end else begin
            pps_in = 1'b1;
            hold = $urandom_range(2, 4);
            case ($urandom_range(0, 9))
               0:       gap = $urandom_range(20, 180);
               1:       gap = $urandom_range(250, 400);
               default: gap = $urandom_range(90, 104);
            endcase
         end
         load_stb = ($urandom_range(0, 63) == 0);
         load_val = $urandom();
         user_rst = ($urandom_range(0, 4999) == 0);
         step();
      end
      user_rst = 1'b0;
      load_stb = 1'b0;
      pps_in   = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
